// File: rtl/spsram_arbiter_pkg.sv
// Shared constants and types for the two-requester SRAM arbiter.
// Default geometry, requester IDs and the read-tracking entry.
package spsram_arbiter_pkg;

    localparam int DW_DEF     = 32;
    localparam int AW_DEF     = 5;
    localparam int RD_LAT_DEF = 1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef struct packed {
        logic vld;
        logic id;
    } rd_ent_t;

    function automatic logic [1:0] id2oh(input logic id);
        return (id == REQ1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spsram_arbiter_if.sv
// Requester-side bus of spsram_arbiter: two req/gnt command ports
// plus the shared read-return channel.
interface spsram_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [1:0]      i_req;
    logic [1:0]      i_wen;
    logic [2*AW-1:0] i_addr;
    logic [2*DW-1:0] i_data;
    logic [1:0]      o_gnt;
    logic [1:0]      o_rvalid;
    logic [DW-1:0]   o_rdata;

    modport master (
        output i_req, i_wen, i_addr, i_data,
        input  o_gnt, o_rvalid, o_rdata
    );

    modport slave (
        input  i_req, i_wen, i_addr, i_data,
        output o_gnt, o_rvalid, o_rdata
    );
endinterface

// File: rtl/spsram_arbiter_rr_arb2.sv
// Two-way round-robin grant with the last-granted pointer.
// Grant is purely a function of the requests and the pointer.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic last_q;
    logic last_d;
    logic [1:0] gnt;

    always_comb begin
        gnt = i_req;
        // on conflict the requester not granted most recently wins
        if (&i_req)
            gnt = last_q ? 2'b01 : 2'b10;
        last_d = (|gnt) ? gnt[1] : last_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end

    assign o_gnt = gnt;
endmodule

// File: rtl/spsram_double.sv
// 32x32 single-port SRAM model: write and read sampled on the rising edge,
// read data appears RD_LAT cycles after the sampling edge.
module spsram_double #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_cen,
    input  logic          i_wen,
    input  logic          i_oen,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_q  [RD_LAT];

    always_ff @(posedge i_clk) begin
        if (i_cen & i_wen)
            mem_q[i_addr] <= i_data;
        if (i_cen & i_oen)
            rd_q[0] <= mem_q[i_addr];
        for (int k = 1; k < RD_LAT; k++)
            rd_q[k] <= rd_q[k-1];
    end

    assign o_data = rd_q[RD_LAT-1];
endmodule

// File: rtl/spsram_arbiter.sv
// Round-robin front end for spsram_double: registers one SRAM command
// per cycle and returns read data with a per-requester valid strobe.
module spsram_arbiter
    import spsram_arbiter_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    spsram_arbiter_if.slave      bus,
    output logic                 o_sram_cen,
    output logic                 o_sram_wen,
    output logic                 o_sram_oen,
    output logic [AW-1:0]        o_sram_addr,
    output logic [DW-1:0]        o_sram_data,
    input  logic [DW-1:0]        i_sram_data
);
    logic [1:0]    gnt;
    logic          xfer;
    logic          sel;
    logic          sel_wen;

    logic          cen_q,  cen_d;
    logic          wen_q,  wen_d;
    logic          oen_q,  oen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    rd_ent_t              ent_d;
    rd_ent_t [RD_LAT:0]   pipe_q;

    rr_arb2 u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (bus.i_req),
        .o_gnt (gnt)
    );

    always_comb begin
        xfer    = |gnt;
        sel     = gnt[1];
        sel_wen = sel ? bus.i_wen[1] : bus.i_wen[0];
        cen_d   = xfer;
        wen_d   = xfer & sel_wen;
        oen_d   = xfer & ~sel_wen;
        addr_d  = addr_q;
        data_d  = data_q;
        if (xfer) begin
            addr_d = sel ? bus.i_addr[2*AW-1:AW] : bus.i_addr[AW-1:0];
            data_d = sel ? bus.i_data[2*DW-1:DW] : bus.i_data[DW-1:0];
        end
        ent_d.vld = xfer & ~sel_wen;
        ent_d.id  = sel ? REQ1 : REQ0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cen_q  <= 1'b0;
            wen_q  <= 1'b0;
            oen_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            pipe_q <= '0;
        end else begin
            cen_q     <= cen_d;
            wen_q     <= wen_d;
            oen_q     <= oen_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pipe_q[0] <= ent_d;
            // slot k lines up with the SRAM being k cycles past the command
            for (int k = 1; k <= RD_LAT; k++)
                pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign bus.o_gnt    = gnt;
    assign bus.o_rvalid = pipe_q[RD_LAT].vld ? id2oh(pipe_q[RD_LAT].id) : 2'b00;
    assign bus.o_rdata  = i_sram_data;

    assign o_sram_cen  = cen_q;
    assign o_sram_wen  = wen_q;
    assign o_sram_oen  = oen_q;
    assign o_sram_addr = addr_q;
    assign o_sram_data = data_q;
endmodule
